// File: rtl/fetch_unit_if.sv
// Fetch-unit signal bundle: instruction-memory side, hazard controls,
// and the values presented to the fetch/decode latch.
interface fetch_unit_if #(
  parameter int WORD_W = 32
);
  logic              ihit;
  logic [WORD_W-1:0] imemload;
  logic              stall;
  logic              redirect;
  logic [WORD_W-1:0] redirect_pc;
  logic              halt;
  logic              imemREN;
  logic [WORD_W-1:0] imemaddr;
  logic              fetch_valid;
  logic [WORD_W-1:0] fetch_instr;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] pc4;
  logic [WORD_W-1:0] next_pc;

  modport master (
    input  ihit, imemload, stall,
    input  redirect, redirect_pc, halt,
    output imemREN, imemaddr, fetch_valid,
    output fetch_instr, pc, pc4, next_pc
  );

  modport slave (
    output ihit, imemload, stall,
    output redirect, redirect_pc, halt,
    input  imemREN, imemaddr, fetch_valid,
    input  fetch_instr, pc, pc4, next_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, holds the address across misses
// and defers redirects that land while a miss is outstanding.
module fetch_unit #(
  parameter int                WORD_W  = 32,
  parameter logic [WORD_W-1:0] PC_INIT = '0
) (
  input logic          CLK,
  input logic          nRST,
  fetch_unit_if.master fif
);
  typedef enum logic [1:0] {
    RUN,
    SQUASH,
    HALT
  } state_t;

  state_t            state, state_n;
  logic [WORD_W-1:0] pc_q, pc_n;
  logic [WORD_W-1:0] pend_q, pend_n;
  logic [WORD_W-1:0] pc4_w;
  logic              fv;

  assign pc4_w = pc_q + WORD_W'(4);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= RUN;
      pc_q   <= PC_INIT;
      pend_q <= '0;
    end else begin
      state  <= state_n;
      pc_q   <= pc_n;
      pend_q <= pend_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc_q;
    pend_n  = pend_q;
    fv      = 1'b0;
    unique case (state)
      RUN: begin
        if (fif.halt) begin
          state_n = HALT;
        end else if (fif.redirect) begin
          if (fif.ihit) begin
            pc_n = fif.redirect_pc;
          end else begin
            pend_n  = fif.redirect_pc;
            state_n = SQUASH;
          end
        end else if (fif.ihit) begin
          fv = 1'b1;
          if (!fif.stall) pc_n = pc4_w;
        end
      end
      SQUASH: begin
        // the in-flight fetch is wrong-path; only its completion matters
        if (fif.halt) begin
          state_n = HALT;
        end else if (fif.redirect) begin
          pend_n = fif.redirect_pc;
          if (fif.ihit) begin
            pc_n    = fif.redirect_pc;
            state_n = RUN;
          end
        end else if (fif.ihit) begin
          pc_n    = pend_q;
          state_n = RUN;
        end
      end
      HALT: begin
        state_n = HALT;
      end
      default: begin
        state_n = RUN;
      end
    endcase
  end

  always_comb begin
    fif.next_pc = pc4_w;
    if (state != HALT && !fif.halt && fif.redirect) begin
      fif.next_pc = fif.redirect_pc;
    end else if (state == SQUASH) begin
      fif.next_pc = pend_q;
    end
  end

  assign fif.imemREN     = (state != HALT);
  assign fif.imemaddr    = pc_q;
  assign fif.fetch_valid = fv;
  assign fif.fetch_instr = fif.imemload;
  assign fif.pc          = pc_q;
  assign fif.pc4         = pc4_w;
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit; two instances share stimulus,
// one reset to 0 and one to FFFF_FFF8 to exercise the pc4 wrap.
module tb_fetch_unit;
  logic        CLK;
  logic        nRST;
  logic        ihit, stall, redirect, halt;
  logic [31:0] imemload, redirect_pc;

  int checks = 0;
  int errors = 0;

  fetch_unit_if #(.WORD_W(32)) b0 ();
  fetch_unit_if #(.WORD_W(32)) b1 ();

  assign b0.ihit        = ihit;
  assign b0.imemload    = imemload;
  assign b0.stall       = stall;
  assign b0.redirect    = redirect;
  assign b0.redirect_pc = redirect_pc;
  assign b0.halt        = halt;
  assign b1.ihit        = ihit;
  assign b1.imemload    = imemload;
  assign b1.stall       = stall;
  assign b1.redirect    = redirect;
  assign b1.redirect_pc = redirect_pc;
  assign b1.halt        = halt;

  fetch_unit #(.WORD_W(32), .PC_INIT(32'h0000_0000)) dut0 (
    .CLK  (CLK),
    .nRST (nRST),
    .fif  (b0.master)
  );

  fetch_unit #(.WORD_W(32), .PC_INIT(32'hFFFF_FFF8)) dut1 (
    .CLK  (CLK),
    .nRST (nRST),
    .fif  (b1.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        o_ren [2];
  logic [31:0] o_addr[2];
  logic        o_fv  [2];
  logic [31:0] o_ins [2];
  logic [31:0] o_pc  [2];
  logic [31:0] o_pc4 [2];
  logic [31:0] o_npc [2];

  assign o_ren[0]  = b0.imemREN;
  assign o_addr[0] = b0.imemaddr;
  assign o_fv[0]   = b0.fetch_valid;
  assign o_ins[0]  = b0.fetch_instr;
  assign o_pc[0]   = b0.pc;
  assign o_pc4[0]  = b0.pc4;
  assign o_npc[0]  = b0.next_pc;
  assign o_ren[1]  = b1.imemREN;
  assign o_addr[1] = b1.imemaddr;
  assign o_fv[1]   = b1.fetch_valid;
  assign o_ins[1]  = b1.fetch_instr;
  assign o_pc[1]   = b1.pc;
  assign o_pc4[1]  = b1.pc4;
  assign o_npc[1]  = b1.next_pc;

  typedef struct packed {
    logic        ren;
    logic [31:0] addr;
    logic        fv;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] npc;
  } exp_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fe_t;

  exp_t eq[2][$];
  fe_t  fq[2][$];

  // reference model: a PC, an optional deferred target, a halted flag
  logic [31:0] m_pc  [2];
  logic [31:0] m_tgt [2];
  bit          m_has [2];
  bit          m_dead[2];

  function automatic logic [31:0] init_of(int d);
    return (d == 0) ? 32'h0000_0000 : 32'hFFFF_FFF8;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pc[d]   = init_of(d);
      m_tgt[d]  = 32'h0;
      m_has[d]  = 1'b0;
      m_dead[d] = 1'b0;
    end
  endtask

  task automatic step(bit upd);
    exp_t e;
    fe_t  f;
    for (int d = 0; d < 2; d++) begin
      e.ren   = !m_dead[d];
      e.addr  = m_pc[d];
      e.fv    = !m_dead[d] && !m_has[d] && ihit && !halt && !redirect;
      e.instr = imemload;
      e.pc4   = m_pc[d] + 32'd4;
      if (!m_dead[d] && !halt && redirect) e.npc = redirect_pc;
      else if (!m_dead[d] && m_has[d])    e.npc = m_tgt[d];
      else                                 e.npc = m_pc[d] + 32'd4;
      eq[d].push_back(e);
      if (e.fv && !stall) begin
        f.pc    = m_pc[d];
        f.instr = imemload;
        fq[d].push_back(f);
      end
      if (upd && !m_dead[d]) begin
        if (halt) begin
          m_dead[d] = 1'b1;
          m_has[d]  = 1'b0;
        end else if (redirect) begin
          if (ihit) begin
            m_pc[d]  = redirect_pc;
            m_has[d] = 1'b0;
          end else begin
            m_tgt[d] = redirect_pc;
            m_has[d] = 1'b1;
          end
        end else if (ihit) begin
          if (m_has[d]) begin
            m_pc[d]  = m_tgt[d];
            m_has[d] = 1'b0;
          end else if (!stall) begin
            m_pc[d] = m_pc[d] + 32'd4;
          end
        end
      end
    end
  endtask

  task automatic chk(string name, int d, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h want %h at %0t", name, d, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    fe_t  f;
    #2;
    for (int d = 0; d < 2; d++) begin
      if (eq[d].size() > 0) begin
        e = eq[d].pop_front();
        chk("imemREN", d, 32'(o_ren[d]), 32'(e.ren));
        chk("imemaddr", d, o_addr[d], e.addr);
        chk("fetch_valid", d, 32'(o_fv[d]), 32'(e.fv));
        chk("fetch_instr", d, o_ins[d], e.instr);
        chk("pc4", d, o_pc4[d], e.pc4);
        chk("next_pc", d, o_npc[d], e.npc);
        if (o_fv[d] && !stall) begin
          if (fq[d].size() == 0) begin
            chk("unexpected_fetch", d, o_pc[d], 32'hxxxx_xxxx);
          end else begin
            f = fq[d].pop_front();
            chk("fetch_pc", d, o_pc[d], f.pc);
            chk("fetch_data", d, o_ins[d], f.instr);
          end
        end
      end
    end
  end

  task automatic cyc(bit ih, bit st, bit rd, logic [31:0] rp, bit hl);
    @(negedge CLK);
    ihit        = ih;
    stall       = st;
    redirect    = rd;
    redirect_pc = rp;
    halt        = hl;
    imemload    = $urandom;
    #1;
    step(1'b1);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST        = 1'b0;
    ihit        = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    halt        = 1'b0;
    redirect_pc = 32'h0;
    imemload    = $urandom;
    #1;
    model_reset();
    step(1'b0);
    @(negedge CLK);
    imemload = $urandom;
    #1;
    step(1'b0);
    #2;
    nRST = 1'b1;
  endtask

  initial begin
    logic [31:0] rp;
    nRST        = 1'b0;
    ihit        = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    halt        = 1'b0;
    redirect_pc = 32'h0;
    imemload    = 32'h0;
    model_reset();
    do_reset();

    // straight-line fetch, then a 3-cycle stall at pc 8
    cyc(1, 0, 0, 32'h0, 0);
    cyc(1, 0, 0, 32'h0, 0);
    repeat (3) cyc(1, 1, 0, 32'h0, 0);
    cyc(1, 0, 0, 32'h0, 0);
    cyc(1, 0, 0, 32'h0, 0);
    // redirect during a miss, then newest-wins inside SQUASH
    cyc(0, 0, 1, 32'h40, 0);
    cyc(0, 0, 0, 32'h0, 0);
    cyc(1, 0, 0, 32'h0, 0);
    cyc(1, 0, 0, 32'h0, 0);
    cyc(0, 0, 1, 32'h40, 0);
    cyc(1, 0, 1, 32'h80, 0);
    cyc(1, 0, 0, 32'h0, 0);
    // halt beats redirect; stays frozen until reset
    cyc(1, 0, 1, 32'h100, 1);
    repeat (4) cyc(1, 0, 1, 32'h200, 0);
    do_reset();
    repeat (3) cyc(1, 0, 0, 32'h0, 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        rp      = $urandom;
        rp[1:0] = 2'b00;
        cyc($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) == 0, rp, $urandom_range(0, 199) == 0);
      end
    end

    @(negedge CLK);
    #3;
    for (int d = 0; d < 2; d++) begin
      chk("exp_queue_drained", d, 32'(eq[d].size()), 32'd0);
      chk("fetch_queue_drained", d, 32'(fq[d].size()), 32'd0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
